// File: rtl/sram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_ctrl                                                       |
// | Purpose  : valid/ready single-word read/write controller for a 1M x 16     |
// |            asynchronous SRAM, with registered pins and safe bus turnaround |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module sram_ctrl #(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [19:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic [19:0] sram_addr,
  inout  wire  [15:0] sram_io,
  output logic        sram_ce_b,
  output logic        sram_we_b,
  output logic        sram_oe_b,
  output logic        sram_ub_b,
  output logic        sram_lb_b
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  localparam logic [3:0] c_rd_cnt_init = 4'(READ_WAIT - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [19:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_io_oe;
  logic        r_ce_b;
  logic        r_we_b;
  logic        r_oe_b;
  logic        r_ub_b;
  logic        r_lb_b;
  logic        r_rd_valid;
  logic [15:0] r_rd_data;

  logic        w_accept;
  logic [15:0] w_rd_mask;

  assign req_ready = (r_state != S_RD);
  assign w_accept  = req_valid && req_ready;
  // Byte lanes the SRAM was told to drive; the others read back as zero.
  assign w_rd_mask = {{8{~r_ub_b}}, {8{~r_lb_b}}};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 20'd0;
      r_wdata    <= 16'd0;
      r_io_oe    <= 1'b0;
      r_ce_b     <= 1'b1;
      r_we_b     <= 1'b1;
      r_oe_b     <= 1'b1;
      r_ub_b     <= 1'b1;
      r_lb_b     <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 16'd0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_WR: begin
          if (w_accept) begin
            r_addr <= req_addr;
            r_ce_b <= 1'b0;
            r_ub_b <= ~req_be[1];
            r_lb_b <= ~req_be[0];
            if (req_we) begin
              r_state <= S_WR;
              r_we_b  <= 1'b0;
              r_oe_b  <= 1'b1;
              r_io_oe <= 1'b1;
              r_wdata <= req_wdata;
            end else begin
              // io drive and we_b drop on the same edge oe_b asserts, so
              // a write followed directly by a read never overlaps drivers.
              r_state <= S_RD;
              r_we_b  <= 1'b1;
              r_oe_b  <= 1'b0;
              r_io_oe <= 1'b0;
              r_cnt   <= c_rd_cnt_init;
            end
          end else begin
            r_state <= S_IDLE;
            r_io_oe <= 1'b0;
            r_ce_b  <= 1'b1;
            r_we_b  <= 1'b1;
            r_oe_b  <= 1'b1;
            r_ub_b  <= 1'b1;
            r_lb_b  <= 1'b1;
          end
        end
        S_RD: begin
          if (r_cnt == 4'd0) begin
            // The forced IDLE cycle that follows lets oe_b release first.
            r_rd_data  <= sram_io & w_rd_mask;
            r_rd_valid <= 1'b1;
            r_state    <= S_IDLE;
            r_io_oe    <= 1'b0;
            r_ce_b     <= 1'b1;
            r_we_b     <= 1'b1;
            r_oe_b     <= 1'b1;
            r_ub_b     <= 1'b1;
            r_lb_b     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_io_oe <= 1'b0;
          r_ce_b  <= 1'b1;
          r_we_b  <= 1'b1;
          r_oe_b  <= 1'b1;
          r_ub_b  <= 1'b1;
          r_lb_b  <= 1'b1;
        end
      endcase
    end
  end

  assign sram_io   = r_io_oe ? r_wdata : 16'hzzzz;
  assign sram_addr = r_addr;
  assign sram_ce_b = r_ce_b;
  assign sram_we_b = r_we_b;
  assign sram_oe_b = r_oe_b;
  assign sram_ub_b = r_ub_b;
  assign sram_lb_b = r_lb_b;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Request/response controller that drives the 1M x 16 asynchronous SRAM pin interface (addr, io, ce_b, we_b, oe_b, ub_b, lb_b).
- Upstream clients issue single-word reads/writes on a valid/ready handshake. Read data comes back on a one-cycle rd_valid strobe.
- All SRAM pins are registered. Bus turnaround is enforced so that sram_io is never driven by controller and SRAM together.

Parameters:
- READ_WAIT, 1, cycles sram_oe_b/sram_addr held low/stable before read data is captured (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst_b  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  20  word address
- req_wdata  in  16  write data
- req_be  in  2  byte enables, active high; [0] = bits 7:0, [1] = bits 15:8
- rd_valid  out  1  one-cycle strobe, rd_data valid
- rd_data  out  16  read data; disabled bytes return 0
- sram_addr  out  20  SRAM address
- sram_io  inout  16  SRAM data bus; driven only in WR, else high-Z
- sram_ce_b  out  1  chip enable, active low
- sram_we_b  out  1  write enable, active low
- sram_oe_b  out  1  output enable, active low
- sram_ub_b  out  1  upper byte enable, active low
- sram_lb_b  out  1  lower byte enable, active low

Behaviour:
- Reset (async, rst_b low):
  - State goes to IDLE.
  - sram_ce_b, sram_we_b, sram_oe_b, sram_ub_b, sram_lb_b all = 1.
  - sram_addr = 0; sram_io high-Z (drive-enable flop = 0).
  - rd_valid = 0, rd_data = 0, wait counter = 0.
  - Reset mid-operation abandons the operation; a pending read produces no rd_valid.
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - req_ready = 1 in IDLE and WR, 0 in RD.
  - Request fields are sampled only at acceptance.
- FSM states:
  - IDLE: ce_b = we_b = oe_b = 1, io released.
    - Accept write -> WR. Accept read -> RD, counter = READ_WAIT-1.
  - WR (exactly 1 cycle): ce_b = 0, we_b = 0, oe_b = 1, io driven with registered wdata; ub_b = ~be[1], lb_b = ~be[0].
    - SRAM captures on the rising edge ending this cycle.
    - Accept write -> WR (back-to-back, one write per cycle).
    - Accept read -> RD.
    - No request -> IDLE.
  - RD: ce_b = 0, oe_b = 0, we_b = 1, io released; ub_b/lb_b from be.
    - Counter decrements each cycle.
    - On the edge where counter = 0: rd_data <= sram_io with disabled bytes forced to 0; rd_valid = 1 for the next cycle; state -> IDLE.
- Turnaround:
  - The mandatory IDLE cycle after RD releases oe_b before any write drives io.
  - WR->RD needs no gap: io enable and we_b drop on the same edge that oe_b asserts.
- Latency:
  - Write: pins active the cycle after acceptance.
  - Read: rd_valid high READ_WAIT+1 cycles after the acceptance edge.
  - Read occupancy is READ_WAIT+1 cycles including the IDLE cycle.
- Register outputs: all pin outputs are flops updated at the edge that enters each state; no combinational path from req_* to pins.
- req_be = 0: request is accepted and timed normally; ub_b = lb_b = 1, so a write has no effect and a read returns 0.
- Address is taken as-is; no wrap or range check beyond 20 bits.
- rd_data holds its value between strobes.

Test Plan:
- Write 0xBEEF to 0x00010, be = 11, then read 0x00010 -> rd_valid one cycle, rd_data = 0xBEEF, 2 cycles after read acceptance (READ_WAIT = 1).
- Write 0x1234 to 0x00020 with be = 11, then 0xAB55 with be = 10, then read be = 11 -> 0xAB34. Read with be = 01 -> 0x0034.
- Three back-to-back writes (addresses 1, 2, 3; data 0x1111, 0x2222, 0x3333) on consecutive cycles:
  - req_ready stays 1 and sram_we_b is low for 3 consecutive cycles.
  - Readback returns all three values.
- Read then write immediately requested:
  - req_ready is 0 during RD.
  - sram_oe_b returns to 1 for at least one cycle before the io drive enable goes to 1.
  - Checker sees no cycle with oe_b = 0 and controller driving io.
- Assert rst_b low during RD (READ_WAIT = 3):
  - All enables go to 1 immediately and io goes high-Z.
  - No rd_valid appears; after release, req_ready = 1 and a new read completes correctly.
- READ_WAIT = 4: read request -> sram_oe_b low for exactly 4 cycles, rd_valid 5 cycles after acceptance, correct data.
